// File: rtl/input_counter.sv
// Input-side sequencer for the 64-point FFT: accepts samples over valid/ready,
// writes them to the input buffer (optionally bit-reversed) and paces frames.
module input_counter #(
    parameter int DATA_W = 16,
    parameter bit BITREV = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     datain_valid,
    input  logic                     datain_sof,
    input  logic signed [DATA_W-1:0] datain_re,
    input  logic signed [DATA_W-1:0] datain_im,
    output logic                     datain_ready,
    output logic                     wr_en,
    output logic [5:0]               wr_addr,
    output logic signed [DATA_W-1:0] wr_re,
    output logic signed [DATA_W-1:0] wr_im,
    output logic [5:0]               counter_i,
    output logic                     in_ctrl_all_in,
    output logic                     hold_all_in,
    output logic                     frame_full,
    output logic                     frame_err,
    input  logic                     frame_release
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_FULL = 2'b11
    } state_t;

    state_t     state, state_nxt;
    logic [5:0] cnt_nxt;
    logic [5:0] wr_idx;
    logic       accept;
    logic       abort;
    logic       last;
    logic       full_p0;

    function automatic logic [5:0] map_addr(input logic [5:0] idx);
        if (BITREV)
            return {idx[0], idx[1], idx[2], idx[3], idx[4], idx[5]};
        else
            return idx;
    endfunction

    assign accept         = datain_valid & datain_ready;
    assign in_ctrl_all_in = (state == S_LOAD);
    assign hold_all_in    = (state != S_LOAD);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = counter_i;
        wr_idx    = counter_i;
        abort     = 1'b0;
        last      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    wr_idx    = 6'd0;
                    cnt_nxt   = 6'd1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    // A start-of-frame mid-load restarts the frame with this sample
                    if (datain_sof) begin
                        abort   = 1'b1;
                        wr_idx  = 6'd0;
                        cnt_nxt = 6'd1;
                    end else begin
                        cnt_nxt = counter_i + 6'd1;
                        if (counter_i == 6'd63) begin
                            last      = 1'b1;
                            state_nxt = S_FULL;
                        end
                    end
                end
            end
            S_FULL: begin
                if (frame_release)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control stage: state, count, handshake and frame pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            counter_i    <= 6'd0;
            datain_ready <= 1'b0;
            wr_en        <= 1'b0;
            full_p0      <= 1'b0;
            frame_full   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            counter_i    <= cnt_nxt;
            datain_ready <= (state_nxt != S_FULL);
            wr_en        <= accept;
            // frame_full trails the last write by one cycle so the buffer is settled
            full_p0      <= last;
            frame_full   <= full_p0;
            frame_err    <= abort;
        end
    end

    // Write stage: address and sample registered alongside wr_en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr <= 6'd0;
            wr_re   <= '0;
            wr_im   <= '0;
        end else if (accept) begin
            wr_addr <= map_addr(wr_idx);
            wr_re   <= datain_re;
            wr_im   <= datain_im;
        end
    end

endmodule

// File: tb/tb_input_counter.sv
// Bench for input_counter: two instances (bit-reversed and linear addressing)
// share one stimulus stream and are checked against a frame-level model.
module tb_input_counter;

    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic datain_valid = 1'b0;
    logic datain_sof = 1'b0;
    logic frame_release = 1'b0;
    logic signed [DATA_W-1:0] datain_re = '0;
    logic signed [DATA_W-1:0] datain_im = '0;

    logic r1_ready, r1_wr_en, r1_in_ctrl, r1_hold, r1_ff, r1_err;
    logic [5:0] r1_addr, r1_cnt;
    logic signed [DATA_W-1:0] r1_re, r1_im;
    logic r0_ready, r0_wr_en, r0_in_ctrl, r0_hold, r0_ff, r0_err;
    logic [5:0] r0_addr, r0_cnt;
    logic signed [DATA_W-1:0] r0_re, r0_im;

    always #5 clk = ~clk;

    input_counter #(.DATA_W(DATA_W), .BITREV(1'b1)) dut_rev (
        .clk(clk), .rst(rst), .datain_valid(datain_valid), .datain_sof(datain_sof),
        .datain_re(datain_re), .datain_im(datain_im), .datain_ready(r1_ready),
        .wr_en(r1_wr_en), .wr_addr(r1_addr), .wr_re(r1_re), .wr_im(r1_im),
        .counter_i(r1_cnt), .in_ctrl_all_in(r1_in_ctrl), .hold_all_in(r1_hold),
        .frame_full(r1_ff), .frame_err(r1_err), .frame_release(frame_release));

    input_counter #(.DATA_W(DATA_W), .BITREV(1'b0)) dut_lin (
        .clk(clk), .rst(rst), .datain_valid(datain_valid), .datain_sof(datain_sof),
        .datain_re(datain_re), .datain_im(datain_im), .datain_ready(r0_ready),
        .wr_en(r0_wr_en), .wr_addr(r0_addr), .wr_re(r0_re), .wr_im(r0_im),
        .counter_i(r0_cnt), .in_ctrl_all_in(r0_in_ctrl), .hold_all_in(r0_hold),
        .frame_full(r0_ff), .frame_err(r0_err), .frame_release(frame_release));

    int total = 0;
    int bad = 0;

    // Frame-level reference model
    int  m_pos;       // samples stored in the current frame (0 = none yet)
    bit  m_blocked;   // frame complete, waiting for release
    bit  m_ready;
    bit  m_wr_en;
    int  m_widx;
    bit  m_pend;
    bit  m_ff;
    bit  m_err;
    logic signed [DATA_W-1:0] m_re, m_im;

    int ff_seen, err_seen, wr_seen;
    int lin_addrs[$];

    typedef struct {
        bit       v;
        bit       sof;
        bit       rel;
        bit       exp_wr_en;
        int       exp_cnt;
        int       exp_addr_rev;
        bit       exp_err;
        bit       exp_in_ctrl;
    } vec_t;

    function automatic int rev6(int i);
        int r = 0;
        for (int b = 0; b < 6; b++)
            if (((i >> b) & 1) != 0) r = r | (1 << (5 - b));
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_blocked = 0; m_ready = 0; m_wr_en = 0; m_widx = 0;
        m_pend = 0; m_ff = 0; m_err = 0; m_re = '0; m_im = '0;
        ff_seen = 0; err_seen = 0; wr_seen = 0;
        lin_addrs.delete();
    endtask

    task automatic model_edge();
        bit acc, last, err;
        acc = datain_valid && m_ready;
        last = 0; err = 0;
        if (m_blocked && frame_release) m_blocked = 0;
        if (acc) begin
            if (m_pos > 0 && datain_sof) begin
                err = 1; m_widx = 0; m_pos = 1;
            end else begin
                m_widx = m_pos;
                m_pos++;
                if (m_pos == 64) begin
                    m_pos = 0; m_blocked = 1; last = 1;
                end
            end
            m_re = datain_re; m_im = datain_im;
        end
        m_wr_en = acc;
        m_ff    = m_pend;
        m_pend  = last;
        m_err   = err;
        m_ready = !m_blocked;
    endtask

    task automatic check_all();
        chk("ready_rev",   r1_ready, m_ready);
        chk("ready_lin",   r0_ready, m_ready);
        chk("wr_en_rev",   r1_wr_en, m_wr_en);
        chk("wr_en_lin",   r0_wr_en, m_wr_en);
        chk("addr_rev",    r1_addr, rev6(m_widx));
        chk("addr_lin",    r0_addr, m_widx);
        chk("re_rev",      r1_re, m_re);
        chk("im_rev",      r1_im, m_im);
        chk("re_lin",      r0_re, m_re);
        chk("im_lin",      r0_im, m_im);
        chk("cnt_rev",     r1_cnt, m_pos);
        chk("cnt_lin",     r0_cnt, m_pos);
        chk("in_ctrl_rev", r1_in_ctrl, m_pos > 0);
        chk("in_ctrl_lin", r0_in_ctrl, m_pos > 0);
        chk("hold_rev",    r1_hold, m_pos == 0);
        chk("hold_lin",    r0_hold, m_pos == 0);
        chk("full_rev",    r1_ff, m_ff);
        chk("full_lin",    r0_ff, m_ff);
        chk("err_rev",     r1_err, m_err);
        chk("err_lin",     r0_err, m_err);
        if (r1_ff) ff_seen++;
        if (r1_err) err_seen++;
        if (r1_wr_en) wr_seen++;
        if (r0_wr_en) lin_addrs.push_back(int'(r0_addr));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic drive(bit v, bit sof, bit rel, int re);
        datain_valid = v;
        datain_sof = sof;
        frame_release = rel;
        datain_re = DATA_W'(re);
        datain_im = DATA_W'(~re);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_ready",   r1_ready, 0);
        chk("rst_wr_en",   r1_wr_en, 0);
        chk("rst_addr",    r1_addr, 0);
        chk("rst_re",      r1_re, 0);
        chk("rst_im",      r1_im, 0);
        chk("rst_cnt",     r1_cnt, 0);
        chk("rst_in_ctrl", r1_in_ctrl, 0);
        chk("rst_hold",    r1_hold, 1);
        chk("rst_full",    r1_ff, 0);
        chk("rst_err",     r1_err, 0);
        chk("rst_cnt_lin", r0_cnt, 0);
        chk("rst_rdy_lin", r0_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic check_lin_order(string nm);
        chk({nm, "_nwr"}, lin_addrs.size(), 64);
        for (int i = 0; i < lin_addrs.size() && i < 64; i++)
            if (lin_addrs[i] != i) chk({nm, "_order"}, lin_addrs[i], i);
    endtask

    initial begin
        vec_t vt[10];
        vt[0] = '{v:0, sof:0, rel:1, exp_wr_en:0, exp_cnt:0, exp_addr_rev:0,  exp_err:0, exp_in_ctrl:0};
        vt[1] = '{v:1, sof:1, rel:0, exp_wr_en:1, exp_cnt:1, exp_addr_rev:0,  exp_err:0, exp_in_ctrl:1};
        vt[2] = '{v:1, sof:1, rel:0, exp_wr_en:1, exp_cnt:1, exp_addr_rev:0,  exp_err:1, exp_in_ctrl:1};
        vt[3] = '{v:0, sof:0, rel:0, exp_wr_en:0, exp_cnt:1, exp_addr_rev:0,  exp_err:0, exp_in_ctrl:1};
        vt[4] = '{v:1, sof:0, rel:1, exp_wr_en:1, exp_cnt:2, exp_addr_rev:32, exp_err:0, exp_in_ctrl:1};
        vt[5] = '{v:1, sof:0, rel:0, exp_wr_en:1, exp_cnt:3, exp_addr_rev:16, exp_err:0, exp_in_ctrl:1};
        vt[6] = '{v:1, sof:0, rel:0, exp_wr_en:1, exp_cnt:4, exp_addr_rev:48, exp_err:0, exp_in_ctrl:1};
        vt[7] = '{v:1, sof:1, rel:0, exp_wr_en:1, exp_cnt:1, exp_addr_rev:0,  exp_err:1, exp_in_ctrl:1};
        vt[8] = '{v:1, sof:0, rel:0, exp_wr_en:1, exp_cnt:2, exp_addr_rev:32, exp_err:0, exp_in_ctrl:1};
        vt[9] = '{v:0, sof:0, rel:1, exp_wr_en:0, exp_cnt:2, exp_addr_rev:32, exp_err:0, exp_in_ctrl:1};

        model_reset();
        do_reset();

        // Back-to-back frame, bit-reversed addresses, re = index
        drive(0, 0, 0, 0);
        step();
        chk("ready_after_rst", r1_ready, 1);
        for (int i = 0; i < 64; i++) begin
            drive(1, 0, 0, i);
            step();
            chk("bitrev_addr", r1_addr, rev6(i));
            chk("bitrev_data", r1_re, i);
        end
        chk("ready_low_full", r1_ready, 0);

        // Stall in full with valid held high, then release
        drive(1, 0, 0, 100);
        for (int i = 0; i < 10; i++) step();
        chk("full_pulses", ff_seen, 1);
        chk("stall_writes", wr_seen, 64);
        drive(1, 0, 1, 101);
        step();
        chk("ready_after_rel", r1_ready, 1);
        drive(1, 0, 0, 102);
        step();
        chk("restart_addr", r1_addr, 0);
        chk("restart_in_ctrl", r1_in_ctrl, 1);
        drive(0, 0, 0, 0);
        step();

        // Table-driven short sequence from idle
        do_reset();
        step();
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].v, vt[i].sof, vt[i].rel, 200 + i);
            step();
            chk("vec_wr_en", r1_wr_en, vt[i].exp_wr_en);
            chk("vec_cnt", r1_cnt, vt[i].exp_cnt);
            chk("vec_addr", r1_addr, vt[i].exp_addr_rev);
            chk("vec_err", r1_err, vt[i].exp_err);
            chk("vec_in_ctrl", r1_in_ctrl, vt[i].exp_in_ctrl);
        end

        // Random valid gaps, linear addressing
        do_reset();
        drive(0, 0, 0, 0);
        step();
        for (int n = 0; n < 600 && !m_blocked; n++) begin
            drive($urandom_range(0, 1), 0, 0, $urandom_range(0, 65535));
            step();
        end
        check_lin_order("gaps");
        drive(0, 0, 0, 0);
        repeat (2) step();
        chk("gaps_full", ff_seen, 1);

        // Abort on the 20th sample
        do_reset();
        drive(0, 0, 0, 0);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(1, i == 19, 0, 300 + i);
            step();
        end
        chk("sof_err_once", err_seen, 1);
        chk("sof_addr", r1_addr, 0);
        chk("sof_data", r1_re, 319);
        chk("sof_cnt", r1_cnt, 1);
        for (int i = 0; i < 62; i++) begin
            drive(1, 0, 0, 400 + i);
            step();
        end
        drive(0, 0, 0, 0);
        repeat (3) step();
        chk("sof_not_full_yet", ff_seen, 0);
        drive(1, 0, 0, 999);
        step();
        drive(0, 0, 0, 0);
        repeat (2) step();
        chk("sof_full_after_63", ff_seen, 1);
        chk("sof_err_total", err_seen, 1);

        // Asynchronous reset after 30 samples, then a clean frame
        do_reset();
        drive(0, 0, 0, 0);
        step();
        for (int i = 0; i < 30; i++) begin
            drive(1, 0, 0, 500 + i);
            step();
        end
        do_reset();
        chk("rst_no_pulse", ff_seen + err_seen, 0);
        drive(1, 0, 0, 0);
        step();
        for (int i = 0; i < 64; i++) begin
            drive(1, 0, 0, 600 + i);
            step();
        end
        drive(0, 0, 0, 0);
        repeat (2) step();
        check_lin_order("post_rst");
        chk("post_rst_full", ff_seen, 1);

        // Fully random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 65535));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_counter.md
# input_counter

Front-end sequencer for the 64-point FFT processor. It accepts a stream of complex input samples over a valid/ready handshake and writes each one into the FFT input buffer at a 6-bit address, bit-reversed by default. It drives the input-side datapath steering (`in_ctrl_all_in`, `hold_all_in`) and raises a one-cycle `frame_full` pulse once all 64 samples are stored. It then stalls upstream until the output side returns `frame_release`.

## Interface

Parameters:
- `DATA_W`, default 16: width of each real and imaginary sample component.
- `BITREV`, default 1: 1 = write address is the bit-reversed sample index; 0 = linear index.

Ports:
- `clk` input 1: the only clock; all logic on rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `datain_valid` input 1: upstream sample valid.
- `datain_sof` input 1: start-of-frame marker, qualified by `datain_valid`.
- `datain_re` input `DATA_W`: sample real part.
- `datain_im` input `DATA_W`: sample imaginary part.
- `datain_ready` output 1: block can accept a sample (registered).
- `wr_en` output 1: buffer write strobe.
- `wr_addr` output 6: buffer write address.
- `wr_re` output `DATA_W`: registered real part of the sample.
- `wr_im` output `DATA_W`: registered imaginary part of the sample.
- `counter_i` output 6: index of the next sample to be accepted.
- `in_ctrl_all_in` output 1: steers the FFT input mux to the load path.
- `hold_all_in` output 1: holds the FFT stage registers.
- `frame_full` output 1: one-cycle pulse when the 64-sample frame is complete.
- `frame_err` output 1: one-cycle pulse when a frame is aborted and resynchronised.
- `frame_release` input 1: downstream has consumed the frame; the block may reload.

## Operation

- An accept occurs on a rising edge where `datain_valid` = 1 and `datain_ready` = 1.
- States:
  - idle, encoding 2'b00.
  - load, encoding 2'b01.
  - full, encoding 2'b11.
- idle:
  - Outputs: `datain_ready` = 1, `in_ctrl_all_in` = 0, `hold_all_in` = 1, `counter_i` = 0.
  - An accept writes index 0 and moves to load with `counter_i` = 1. `datain_sof` is irrelevant here.
- load:
  - Outputs: `datain_ready` = 1, `in_ctrl_all_in` = 1, `hold_all_in` = 0.
  - An accept with `datain_sof` = 0 writes index `counter_i`, then `counter_i` increments.
  - An accept with `datain_sof` = 1 aborts the partial frame:
    - the sample is written at index 0;
    - `counter_i` becomes 1;
    - `frame_err` pulses;
    - the state stays load.
  - An accept at index 63 moves to full. `counter_i` wraps to 0 and `datain_ready` goes to 0.
- full:
  - Outputs: `datain_ready` = 0, `in_ctrl_all_in` = 0, `hold_all_in` = 1.
  - `frame_release` = 1 moves to idle and sets `datain_ready` = 1.
- Address mapping:
  - `BITREV` = 1: `wr_addr` = {idx[0], idx[1], idx[2], idx[3], idx[4], idx[5]}.
  - `BITREV` = 0: `wr_addr` = idx.
- Count arithmetic is 6-bit unsigned; 63 + 1 wraps to 0, and only the index-63 accept triggers full.
- `frame_release` is ignored in idle and load.
- Reset asserted mid-frame clears all state immediately and discards the partial frame. No `frame_full` or `frame_err` pulse results.

## Timing

- Reset values:
  - state = idle, `counter_i` = 0;
  - `datain_ready` = 0, `wr_en` = 0, `wr_addr` = 0, `wr_re` = 0, `wr_im` = 0;
  - `in_ctrl_all_in` = 0, `hold_all_in` = 1, `frame_full` = 0, `frame_err` = 0.
- `datain_ready` rises at the first rising edge after `rst` deasserts.
- Write latency is 1. For an accept at edge k, `wr_en`, `wr_addr`, `wr_re` and `wr_im` are valid during the cycle after edge k. `wr_en` is 0 in every cycle not preceded by an accept.
- Sample 63 accepted at edge k:
  - `datain_ready` = 0 and state = full after edge k;
  - `frame_full` = 1 during the cycle after edge k+1 only, so the buffer write has completed first.
- `frame_err` is high during the cycle after the aborting accept.
- `in_ctrl_all_in` and `hold_all_in` change on the same edge as the state change.
- `frame_release` sampled at edge m while in full: `datain_ready` = 1 after edge m, and the first accept is possible at edge m+1.
- `frame_release` arriving on the same edge as the index-63 accept is ignored; state was load at that edge.
- Throughput: 1 sample per cycle while loading; at minimum 2 cycles of dead time per frame (full state, then release).

## Test plan

- Reset, then 64 back-to-back valid samples with `re` = index, `BITREV` = 1:
  - writes at addresses 0, 32, 16, 48, …, 63 with the matching data;
  - `frame_full` is a single pulse two edges after the last accept;
  - `datain_ready` = 0 afterwards.
- Hold `datain_valid` = 1 while in full for 10 cycles, then pulse `frame_release`:
  - no `wr_en` during the stall;
  - the next accept lands at index 0, and `in_ctrl_all_in` rises.
- Random `datain_valid` gaps (≈50 % duty) with `BITREV` = 0:
  - 64 writes at addresses 0..63 in order;
  - `counter_i` tracks the accept count;
  - no write on invalid cycles.
- `datain_sof` = 1 on the 20th sample:
  - `frame_err` pulses once;
  - that sample is written at address 0;
  - 63 further samples are needed before `frame_full`.
- Assert `rst` asynchronously, between edges, after 30 samples:
  - all outputs take reset values immediately;
  - the following 64 samples form a clean frame starting at index 0.
- `frame_release` pulsed in idle and in load:
  - no state change;
  - `counter_i` is unaffected.
